// File: rtl/sd_job_sched.sv
// Round-robin scheduler that turns multi-sector write/read jobs into per-sector
// start strobes for a single-sector SD controller, with start-timeout retry.
module sd_job_sched #(
  parameter int SEC_PER_JOB = 8,
  parameter int START_TO    = 15,
  parameter int MAX_RETRY   = 3
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        wr_job_req,
  input  logic [31:0] wr_job_base,
  output logic        wr_job_ack,
  output logic        wr_job_done,
  input  logic        rd_job_req,
  input  logic [31:0] rd_job_base,
  output logic        rd_job_ack,
  output logic        rd_job_done,
  output logic        job_err,
  output logic        sd_wr_start_en,
  output logic [31:0] sd_wr_sec_addr,
  input  logic        sd_wr_busy,
  output logic        sd_rd_start_en,
  output logic [31:0] sd_rd_sec_addr,
  input  logic        sd_rd_busy
);
  localparam int IDX_W = (SEC_PER_JOB > 1) ? $clog2(SEC_PER_JOB) : 1;
  localparam int TO_W  = $clog2(START_TO + 1);
  localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEC_PER_JOB - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TO - 1);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_FINISH
  } state_e;

  // One controller port per direction; index 0 = write, 1 = read.
  typedef struct packed {
    logic        start_en;
    logic [31:0] sec_addr;
  } port_t;

  state_e            state_q,   state_d;
  logic [31:0]       addr_q,    addr_d;
  logic [IDX_W-1:0]  sec_idx_q, sec_idx_d;
  logic [RT_W-1:0]   retry_q,   retry_d;
  logic [TO_W-1:0]   tcnt_q,    tcnt_d;
  logic              dir_q,     dir_d;
  logic              last_rd_q, last_rd_d;
  port_t [1:0]       port_q,    port_d;
  logic  [1:0]       ack_q,     ack_d;
  logic  [1:0]       done_q,    done_d;
  logic              err_q,     err_d;

  logic busy;
  logic grant_rd;

  assign busy     = dir_q ? sd_rd_busy : sd_wr_busy;
  // Read wins only when alone or when write was served last.
  assign grant_rd = rd_job_req && (!wr_job_req || !last_rd_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sec_idx_d = sec_idx_q;
    retry_d   = retry_q;
    tcnt_d    = tcnt_q;
    dir_d     = dir_q;
    last_rd_d = last_rd_q;
    port_d    = port_q;
    port_d[0].start_en = 1'b0;
    port_d[1].start_en = 1'b0;
    ack_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    case (state_q)
      S_INIT:
        if (sd_init_done) state_d = S_IDLE;
      S_IDLE:
        if (wr_job_req || rd_job_req) begin
          dir_d           = grant_rd;
          last_rd_d       = grant_rd;
          ack_d[grant_rd] = 1'b1;
          addr_d          = grant_rd ? rd_job_base : wr_job_base;
          sec_idx_d       = '0;
          retry_d         = '0;
          state_d         = S_ISSUE;
        end
      S_ISSUE: begin
        port_d[dir_q].start_en = 1'b1;
        port_d[dir_q].sec_addr = addr_q;
        tcnt_d                 = '0;
        state_d                = S_WAIT_HI;
      end
      S_WAIT_HI:
        if (busy) begin
          state_d = S_WAIT_LO;
        end else if (tcnt_q == TO_LAST) begin
          if (retry_q < RT_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      S_WAIT_LO:
        if (!busy) state_d = S_NEXT;
      S_NEXT:
        if (sec_idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          sec_idx_d = sec_idx_q + 1'b1;
          addr_d    = addr_q + 32'd1;
          retry_d   = '0;
          state_d   = S_ISSUE;
        end
      S_FINISH: begin
        done_d[dir_q] = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      addr_q    <= '0;
      sec_idx_q <= '0;
      retry_q   <= '0;
      tcnt_q    <= '0;
      dir_q     <= 1'b0;
      last_rd_q <= 1'b1;
      port_q    <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sec_idx_q <= sec_idx_d;
      retry_q   <= retry_d;
      tcnt_q    <= tcnt_d;
      dir_q     <= dir_d;
      last_rd_q <= last_rd_d;
      port_q    <= port_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_job_ack     = ack_q[0];
  assign rd_job_ack     = ack_q[1];
  assign wr_job_done    = done_q[0];
  assign rd_job_done    = done_q[1];
  assign job_err        = err_q;
  assign sd_wr_start_en = port_q[0].start_en;
  assign sd_wr_sec_addr = port_q[0].sec_addr;
  assign sd_rd_start_en = port_q[1].start_en;
  assign sd_rd_sec_addr = port_q[1].sec_addr;

endmodule
